// File: rtl/audio_level_meter_pkg.sv
// Shared defaults, mode encoding and pipeline stage numbering for the
// audio level meter.
package audio_meter_pkg;

   // Default configuration
   localparam int DEF_SAMPLE_W = 8;
   localparam int DEF_NUM_CH   = 2;
   localparam int DEF_WIN_LOG2 = 8;
   localparam int DEF_LED_N    = 8;
   localparam int DEF_HOLD_WIN = 4;

   // Display mode, latched when a window closes
   typedef enum logic {
      MODE_AVG  = 1'b0,
      MODE_PEAK = 1'b1
   } mode_e;

   // Pipeline stages counted in cycles after the closing sample:
   // SNAP holds the window snapshot, OUT holds the registered outputs.
   localparam int STAGE_SNAP = 1;
   localparam int STAGE_OUT  = 2;

endpackage

// File: rtl/audio_level_meter_if.sv
// Sample stream in, level report out.
//
// Handshake: there is no ready. Every cycle with sample_valid=1 delivers one
// sample per channel and it is always consumed; silent only qualifies that
// cycle (the sample is counted but contributes zero). level_valid is a
// one-cycle pulse marking a new level_out/led_out; both hold in between.
interface audio_level_meter_if
   import audio_meter_pkg::*;
#(
   parameter int SAMPLE_W = DEF_SAMPLE_W,
   parameter int NUM_CH   = DEF_NUM_CH,
   parameter int LED_N    = DEF_LED_N
);
   logic                         sample_valid;
   logic [NUM_CH*SAMPLE_W-1:0]   sample;
   logic                         silent;
   logic                         mode;
   logic [NUM_CH*SAMPLE_W-1:0]   level_out;
   logic [NUM_CH*LED_N-1:0]      led_out;
   logic                         level_valid;

   modport master (
      output sample_valid, sample, silent, mode,
      input  level_out, led_out, level_valid
   );

   modport slave (
      input  sample_valid, sample, silent, mode,
      output level_out, led_out, level_valid
   );
endinterface

// File: rtl/audio_level_meter_level_to_bar.sv
// Level to thermometer bar. Segment j lights when the level exceeds
// 2^(j+SAMPLE_W-LED_N); thresholds rise with j, so lit segments are always
// contiguous and the bar fills from its MSB downward.
module level_to_bar #(
   parameter int SAMPLE_W = 8,
   parameter int LED_N    = 8
) (
   input  logic [SAMPLE_W-1:0] level,
   output logic [LED_N-1:0]    bar
);

   for (genvar j = 0; j < LED_N; j++) begin : g_seg
      localparam logic [SAMPLE_W-1:0] THRESH = SAMPLE_W'(1) << (j + SAMPLE_W - LED_N);
      assign bar[LED_N-1-j] = (level > THRESH);
   end

endmodule

// File: rtl/audio_level_meter.sv
// Multi-channel audio level meter: accumulates |sample| and peak over a
// window of 2^WIN_LOG2 accepted samples, then reports average or held peak
// per channel together with an LED bar, two cycles after the closing sample.
module audio_level_meter
   import audio_meter_pkg::*;
#(
   parameter int SAMPLE_W = DEF_SAMPLE_W,
   parameter int NUM_CH   = DEF_NUM_CH,
   parameter int WIN_LOG2 = DEF_WIN_LOG2,
   parameter int LED_N    = DEF_LED_N,
   parameter int HOLD_WIN = DEF_HOLD_WIN
) (
   input logic                clk,
   input logic                rst_n,
   audio_level_meter_if.slave bus
);

   // Wide enough for 2^WIN_LOG2 magnitudes of at most 2^(SAMPLE_W-1)
   localparam int ACC_W = SAMPLE_W + WIN_LOG2;
   localparam int AGE_W = (HOLD_WIN > 1) ? $clog2(HOLD_WIN) : 1;

   if (LED_N > SAMPLE_W) begin : g_bad_led_n
      $error("audio_level_meter: LED_N must not exceed SAMPLE_W");
   end
   if (HOLD_WIN < 1) begin : g_bad_hold_win
      $error("audio_level_meter: HOLD_WIN must be at least 1");
   end

   // Two's complement magnitude; the most negative code maps to 2^(SAMPLE_W-1)
   function automatic logic [SAMPLE_W-1:0] magnitude(input logic [SAMPLE_W-1:0] x);
      return x[SAMPLE_W-1] ? (~x + SAMPLE_W'(1)) : x;
   endfunction

   logic [WIN_LOG2-1:0]       win_cnt;
   logic                      win_close;
   logic [SAMPLE_W-1:0]       contrib   [NUM_CH];
   logic [ACC_W-1:0]          acc       [NUM_CH];
   logic [ACC_W-1:0]          acc_add   [NUM_CH];
   logic [SAMPLE_W-1:0]       peak      [NUM_CH];
   logic [SAMPLE_W-1:0]       peak_upd  [NUM_CH];
   logic [SAMPLE_W-1:0]       snap_avg  [NUM_CH];
   logic [SAMPLE_W-1:0]       snap_peak [NUM_CH];
   mode_e                     snap_mode;
   logic [STAGE_OUT:STAGE_SNAP] pipe_v;
   logic [SAMPLE_W-1:0]       held      [NUM_CH];
   logic [SAMPLE_W-1:0]       held_nxt  [NUM_CH];
   logic [AGE_W-1:0]          age       [NUM_CH];
   logic [AGE_W-1:0]          age_nxt   [NUM_CH];
   logic [SAMPLE_W-1:0]       level_nxt [NUM_CH];
   logic [SAMPLE_W-1:0]       level_q   [NUM_CH];
   logic [LED_N-1:0]          bar_nxt   [NUM_CH];
   logic [LED_N-1:0]          bar_q     [NUM_CH];

   // The window closes on the sample that brings the counter back to zero
   assign win_close = bus.sample_valid && (win_cnt == '1);

   // Per-channel contribution of the current cycle and the running totals it produces
   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         contrib[c] = '0;
         if (bus.sample_valid && !bus.silent) begin
            contrib[c] = magnitude(bus.sample[c*SAMPLE_W +: SAMPLE_W]);
         end
         acc_add[c]  = acc[c] + ACC_W'(contrib[c]);
         peak_upd[c] = (contrib[c] > peak[c]) ? contrib[c] : peak[c];
      end
   end

   // Window accumulation; at close the totals (including the closing sample)
   // are snapshotted and cleared in the same cycle so the next sample starts afresh
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         win_cnt   <= '0;
         snap_mode <= MODE_AVG;
         for (int c = 0; c < NUM_CH; c++) begin
            acc[c]       <= '0;
            peak[c]      <= '0;
            snap_avg[c]  <= '0;
            snap_peak[c] <= '0;
         end
      end else if (bus.sample_valid) begin
         win_cnt <= win_cnt + 1'b1;
         for (int c = 0; c < NUM_CH; c++) begin
            if (win_close) begin
               acc[c]       <= '0;
               peak[c]      <= '0;
               snap_avg[c]  <= acc_add[c][ACC_W-1:WIN_LOG2];
               snap_peak[c] <= peak_upd[c];
            end else begin
               acc[c]  <= acc_add[c];
               peak[c] <= peak_upd[c];
            end
         end
         if (win_close) begin
            snap_mode <= mode_e'(bus.mode);
         end
      end
   end

   // Stage valid flags: snapshot ready, then outputs ready
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pipe_v <= '0;
      end else begin
         pipe_v <= {pipe_v[STAGE_SNAP], win_close};
      end
   end

   // Peak-hold decision and output level selection from the snapshot
   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         held_nxt[c] = held[c];
         age_nxt[c]  = '0;
         if (snap_peak[c] >= held[c]) begin
            held_nxt[c] = snap_peak[c];
         end else if (age[c] == AGE_W'(HOLD_WIN - 1)) begin
            held_nxt[c] = snap_peak[c];
         end else begin
            age_nxt[c] = age[c] + 1'b1;
         end
         level_nxt[c] = (snap_mode == MODE_PEAK) ? held_nxt[c] : snap_avg[c];
      end
   end

   // Commit hold state and register the outputs once per window
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int c = 0; c < NUM_CH; c++) begin
            held[c]    <= '0;
            age[c]     <= '0;
            level_q[c] <= '0;
            bar_q[c]   <= '0;
         end
      end else if (pipe_v[STAGE_SNAP]) begin
         for (int c = 0; c < NUM_CH; c++) begin
            held[c]    <= held_nxt[c];
            age[c]     <= age_nxt[c];
            level_q[c] <= level_nxt[c];
            bar_q[c]   <= bar_nxt[c];
         end
      end
   end

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      level_to_bar #(
         .SAMPLE_W (SAMPLE_W),
         .LED_N    (LED_N)
      ) u_bar (
         .level (level_nxt[c]),
         .bar   (bar_nxt[c])
      );
      assign bus.level_out[c*SAMPLE_W +: SAMPLE_W] = level_q[c];
      assign bus.led_out[c*LED_N +: LED_N]         = bar_q[c];
   end

   assign bus.level_valid = pipe_v[STAGE_OUT];

endmodule

// File: tb/tb_audio_level_meter.sv
// Directed bench for audio_level_meter with default parameters. Drivers push
// the expected report when they issue a window's last sample; a monitor pops
// and compares on every level_valid pulse and checks outputs hold in between.
module tb_audio_level_meter;

   localparam int SW = 8;
   localparam int NC = 2;
   localparam int LN = 8;

   // Clock and reset
   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   audio_level_meter_if #(.SAMPLE_W(SW), .NUM_CH(NC), .LED_N(LN)) bus ();

   audio_level_meter #(
      .SAMPLE_W (SW),
      .NUM_CH   (NC),
      .WIN_LOG2 (8),
      .LED_N    (LN),
      .HOLD_WIN (4)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Scoreboard: {expected pulse cycle, level1, level0, led1, led0}
   logic [63:0] exp_q[$];
   logic [63:0] mon_e;
   logic [31:0] last_hold = '0;
   logic        mon_en    = 1'b0;
   int          errors    = 0;
   int          checks    = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor
   always @(negedge clk) begin
      if (!rst_n) begin
         last_hold = '0;
      end else if (mon_en) begin
         if (bus.level_valid) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_pulse: level_out=%h led_out=%h at cycle %0d, nothing expected",
                        bus.level_out, bus.led_out, cyc);
            end else begin
               mon_e = exp_q.pop_front();
               check("pulse_cycle", cyc, mon_e[63:32]);
               check("level_out", {16'h0, bus.level_out}, {16'h0, mon_e[31:16]});
               check("led_out", {16'h0, bus.led_out}, {16'h0, mon_e[15:0]});
               last_hold = mon_e[31:0];
            end
         end else begin
            check("hold_outputs", {bus.level_out, bus.led_out}, last_hold);
         end
      end
   end

   // Drivers
   task automatic do_reset();
      @(posedge clk);
      #2;
      rst_n            = 1'b0;
      bus.sample_valid = 1'b0;
      #1;
      check("reset_level", {16'h0, bus.level_out}, 32'h0);
      check("reset_led", {16'h0, bus.led_out}, 32'h0);
      check("reset_valid", {31'h0, bus.level_valid}, 32'h0);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
   endtask

   task automatic drive(input logic [7:0] c0, input logic [7:0] c1, input logic sil);
      @(negedge clk);
      bus.sample_valid = 1'b1;
      bus.sample       = {c1, c0};
      bus.silent       = sil;
   endtask

   task automatic idle();
      @(negedge clk);
      bus.sample_valid = 1'b0;
      bus.sample       = 16'($urandom_range(0, 65535));
      bus.silent       = 1'($urandom_range(0, 1));
   endtask

   task automatic settle();
      repeat (4) idle();
   endtask

   task automatic push_exp(input logic [7:0] l0, input logic [7:0] l1,
                           input logic [7:0] d0, input logic [7:0] d1);
      exp_q.push_back({cyc + 32'd2, l1, l0, d1, d0});
   endtask

   // One window: first sample f0/f1, remaining 255 c0/c1, gap idle cycles after each
   task automatic run_window(input logic [7:0] f0, input logic [7:0] f1,
                             input logic [7:0] c0, input logic [7:0] c1,
                             input logic sil, input int gap,
                             input logic [7:0] l0, input logic [7:0] l1,
                             input logic [7:0] d0, input logic [7:0] d1);
      for (int i = 0; i < 256; i++) begin
         if (i == 0) drive(f0, f1, sil);
         else        drive(c0, c1, sil);
         if (i == 255) push_exp(l0, l1, d0, d1);
         repeat (gap) idle();
      end
   endtask

   initial begin
      bus.sample_valid = 1'b0;
      bus.sample       = '0;
      bus.silent       = 1'b0;
      bus.mode         = 1'b0;

      do_reset();
      mon_en = 1'b1;

      // Steady average, negative / most-negative inputs, silent window
      run_window(8'h10, 8'h10, 8'h10, 8'h10, 1'b0, 0, 8'h10, 8'h10, 8'hF0, 8'hF0);
      settle();
      run_window(8'h80, 8'hF0, 8'h80, 8'hF0, 1'b0, 0, 8'h80, 8'h10, 8'hFE, 8'hF0);
      settle();
      run_window(8'h7F, 8'h7F, 8'h7F, 8'h7F, 1'b1, 0, 8'h00, 8'h00, 8'h00, 8'h00);
      settle();

      // Peak hold: 0x60 held for four windows, released on the fifth
      do_reset();
      bus.mode = 1'b1;
      run_window(8'h60, 8'h60, 8'h00, 8'h00, 1'b0, 0, 8'h60, 8'h60, 8'hFE, 8'hFE);
      for (int w = 0; w < 3; w++)
         run_window(8'h02, 8'h02, 8'h02, 8'h02, 1'b0, 0, 8'h60, 8'h60, 8'hFE, 8'hFE);
      run_window(8'h02, 8'h02, 8'h02, 8'h02, 1'b0, 0, 8'h02, 8'h02, 8'h80, 8'h80);
      settle();
      bus.mode = 1'b0;

      // Reset mid-window discards the partial window
      for (int i = 0; i < 100; i++) drive(8'h7F, 8'h7F, 1'b0);
      do_reset();
      run_window(8'h04, 8'h04, 8'h04, 8'h04, 1'b0, 0, 8'h04, 8'h04, 8'hC0, 8'hC0);
      settle();

      // Back-to-back windows, continuous valid then valid every third cycle
      run_window(8'h08, 8'h08, 8'h08, 8'h08, 1'b0, 0, 8'h08, 8'h08, 8'hE0, 8'hE0);
      run_window(8'h20, 8'h20, 8'h20, 8'h20, 1'b0, 0, 8'h20, 8'h20, 8'hF8, 8'hF8);
      settle();
      run_window(8'h08, 8'h08, 8'h08, 8'h08, 1'b0, 2, 8'h08, 8'h08, 8'hE0, 8'hE0);
      run_window(8'h20, 8'h20, 8'h20, 8'h20, 1'b0, 2, 8'h20, 8'h20, 8'hF8, 8'hF8);
      settle();

      // Mode only matters at close: peak->avg mid-window gives average 0x20,
      // avg->peak mid-window gives held peak 0x40
      bus.mode = 1'b1;
      for (int i = 0; i < 256; i++) begin
         if (i == 128) bus.mode = 1'b0;
         if (i[0]) drive(8'h40, 8'h40, 1'b0);
         else      drive(8'h00, 8'h00, 1'b0);
         if (i == 255) push_exp(8'h20, 8'h20, 8'hF8, 8'hF8);
      end
      for (int i = 0; i < 256; i++) begin
         if (i == 128) bus.mode = 1'b1;
         if (i[0]) drive(8'h40, 8'h40, 1'b0);
         else      drive(8'h00, 8'h00, 1'b0);
         if (i == 255) push_exp(8'h40, 8'h40, 8'hFC, 8'hFC);
      end
      settle();
      bus.mode = 1'b0;

      // Drain with a bounded wait
      repeat (10) idle();
      if (exp_q.size() != 0) begin
         $display("FAIL missing_pulse: %0d expected reports never arrived, required 0",
                  exp_q.size());
         errors += exp_q.size();
         checks += exp_q.size();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
